eda_flood_ctrl: RTL



---
 rtl/eda_flood_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/eda_flood_ctrl.sv
// Plateau-flood sequencer for the regional-maximum engine: raster scan, BFS over each plateau, mask replay.
// Optional build macro EDA_FLOOD_STATS_EN adds the region_count / max_region_count outputs.
module eda_flood_ctrl #(
    parameter int unsigned M          = 16,
    parameter int unsigned N          = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(M*N),
    parameter int unsigned NEIGH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  win_req_valid,
    input  logic                  win_req_ready,
    output logic [ADDR_WIDTH-1:0] win_center_addr,
    output logic [NEIGH-1:0]      neigh_addr_valid,
    output logic [NEIGH-1:0]      iterated_idx,
    input  logic                  cmp_valid,
    input  logic                  cmp_max,
    input  logic [NEIGH-1:0]      cmp_push,
`ifdef EDA_FLOOD_STATS_EN
    output logic [ADDR_WIDTH:0]   region_count,
    output logic [ADDR_WIDTH:0]   max_region_count,
`endif
    output logic                  mask_wr_en,
    output logic [ADDR_WIDTH-1:0] mask_wr_addr,
    output logic                  mask_wr_data,
    output logic                  region_done
);

    localparam int unsigned NPIX  = M * N;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned KW    = $clog2(NEIGH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NPIX - 1);
    localparam logic [ADDR_WIDTH-1:0] N_A      = ADDR_WIDTH'(N);
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_POP, S_REQ, S_WAIT, S_PUSH, S_REPLAY, S_DONE
    } state_e;

    // Neighbour k address; only meaningful where the matching valid bit is set.
    function automatic logic [ADDR_WIDTH-1:0] nb_addr(input logic [ADDR_WIDTH-1:0] c,
                                                      input logic [KW-1:0] k);
        case (k)
            KW'(0):  nb_addr = c - N_A - ONE_A;
            KW'(1):  nb_addr = c - N_A;
            KW'(2):  nb_addr = c - N_A + ONE_A;
            KW'(3):  nb_addr = c - ONE_A;
            KW'(4):  nb_addr = c + ONE_A;
            KW'(5):  nb_addr = c + N_A - ONE_A;
            KW'(6):  nb_addr = c + N_A;
            default: nb_addr = c + N_A + ONE_A;
        endcase
    endfunction

    function automatic logic [NEIGH-1:0] nb_valid(input logic [ADDR_WIDTH-1:0] c);
        logic [ADDR_WIDTH-1:0] row;
        logic [ADDR_WIDTH-1:0] col;
        row      = c / N_A;
        col      = c % N_A;
        nb_valid = '1;
        if (row == '0)                      nb_valid[2:0] = 3'b000;
        if (row == ADDR_WIDTH'(M - 1))      nb_valid[7:5] = 3'b000;
        if (col == '0)          begin nb_valid[0] = 1'b0; nb_valid[3] = 1'b0; nb_valid[5] = 1'b0; end
        if (col == N_A - ONE_A) begin nb_valid[2] = 1'b0; nb_valid[4] = 1'b0; nb_valid[7] = 1'b0; end
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] scan_q, scan_d, cur_q, cur_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, idx_q, idx_d;
    logic [NEIGH-1:0]      pend_q, pend_d;
    logic                  flag_q, flag_d, busy_q, busy_d, done_q;
    logic [NPIX-1:0]       visited_q;
    logic [ADDR_WIDTH-1:0] q_mem [NPIX];

    logic                  win_req_valid_q;
    logic [ADDR_WIDTH-1:0] win_center_addr_q;
    logic [NEIGH-1:0]      nav_q, iter_q, nv_c, it_c;
    logic                  mask_en_q, mask_en_d, mask_data_q, mask_data_d;
    logic                  mask_last_q, mask_last_d, region_done_q;
    logic [ADDR_WIDTH-1:0] mask_addr_q, mask_addr_d;

    logic                  q_we, vis_set, vis_clr, req_live;
    logic [ADDR_WIDTH-1:0] q_waddr, q_wdata, vis_addr, push_addr;
    logic [KW-1:0]         pick;

    // Lowest pending neighbour to enqueue this cycle.
    always_comb begin
        pick = '0;
        for (int k = NEIGH - 1; k >= 0; k--) begin
            if (pend_q[k]) pick = KW'(k);
        end
        push_addr = nb_addr(cur_q, pick);
    end

    // Window side-band vectors for the centre being (or about to be) requested.
    always_comb begin
        nv_c = nb_valid(cur_d);
        it_c = '0;
        for (int k = 0; k < NEIGH; k++) begin
            if (nv_c[k]) it_c[k] = visited_q[nb_addr(cur_d, KW'(k))];
        end
    end

    always_comb begin
        state_d     = state_q;
        scan_d      = scan_q;
        head_d      = head_q;
        tail_d      = tail_q;
        idx_d       = idx_q;
        cur_d       = cur_q;
        pend_d      = pend_q;
        flag_d      = flag_q;
        busy_d      = busy_q;
        q_we        = 1'b0;
        q_waddr     = '0;
        q_wdata     = '0;
        vis_set     = 1'b0;
        vis_clr     = 1'b0;
        vis_addr    = '0;
        mask_en_d   = 1'b0;
        mask_addr_d = '0;
        mask_data_d = 1'b0;
        mask_last_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    scan_d  = '0;
                    vis_clr = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_SCAN: begin
                if (visited_q[scan_q]) begin
                    if (scan_q == LAST_PIX) state_d = S_DONE;
                    else                    scan_d  = scan_q + ONE_A;
                end else begin
                    q_we     = 1'b1;
                    q_waddr  = '0;
                    q_wdata  = scan_q;
                    vis_set  = 1'b1;
                    vis_addr = scan_q;
                    head_d   = '0;
                    tail_d   = PTR_W'(1);
                    flag_d   = 1'b1;
                    state_d  = S_POP;
                end
            end
            S_POP: begin
                if (head_q == tail_q) begin
                    idx_d   = '0;
                    state_d = S_REPLAY;
                end else begin
                    cur_d   = q_mem[ADDR_WIDTH'(head_q)];
                    head_d  = head_q + PTR_W'(1);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (win_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cmp_valid) begin
                    flag_d  = flag_q & cmp_max;
                    pend_d  = cmp_push & nav_q & ~iter_q;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (pend_q == '0) begin
                    state_d = S_POP;
                end else begin
                    q_we     = 1'b1;
                    q_waddr  = ADDR_WIDTH'(tail_q);
                    q_wdata  = push_addr;
                    vis_set  = 1'b1;
                    vis_addr = push_addr;
                    tail_d   = tail_q + PTR_W'(1);
                    pend_d   = pend_q & ~(NEIGH'(1) << pick);
                end
            end
            S_REPLAY: begin
                mask_en_d   = 1'b1;
                mask_addr_d = q_mem[ADDR_WIDTH'(idx_q)];
                mask_data_d = flag_q;
                idx_d       = idx_q + PTR_W'(1);
                if (idx_q == tail_q - PTR_W'(1)) begin
                    mask_last_d = 1'b1;
                    if (scan_q == LAST_PIX) begin
                        state_d = S_DONE;
                    end else begin
                        scan_d  = scan_q + ONE_A;
                        state_d = S_SCAN;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_live = (state_d == S_REQ) || (state_d == S_WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_IDLE;
            scan_q            <= '0;
            head_q            <= '0;
            tail_q            <= '0;
            idx_q             <= '0;
            cur_q             <= '0;
            pend_q            <= '0;
            flag_q            <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            win_req_valid_q   <= 1'b0;
            win_center_addr_q <= '0;
            nav_q             <= '0;
            iter_q            <= '0;
            mask_en_q         <= 1'b0;
            mask_addr_q       <= '0;
            mask_data_q       <= 1'b0;
            mask_last_q       <= 1'b0;
            region_done_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            scan_q            <= scan_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            idx_q             <= idx_d;
            cur_q             <= cur_d;
            pend_q            <= pend_d;
            flag_q            <= flag_d;
            busy_q            <= busy_d;
            done_q            <= (state_q == S_DONE);
            win_req_valid_q   <= (state_d == S_REQ);
            win_center_addr_q <= req_live ? cur_d : '0;
            nav_q             <= req_live ? nv_c : '0;
            iter_q            <= req_live ? it_c : '0;
            mask_en_q         <= mask_en_d;
            mask_addr_q       <= mask_addr_d;
            mask_data_q       <= mask_data_d;
            mask_last_q       <= mask_last_d;
            region_done_q     <= mask_en_q & mask_last_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     visited_q           <= '0;
        else if (vis_clr) visited_q           <= '0;
        else if (vis_set) visited_q[vis_addr] <= 1'b1;
    end

    // Shared BFS queue and region member list.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPIX; i++) q_mem[i] <= '0;
        end else if (q_we) begin
            q_mem[q_waddr] <= q_wdata;
        end
    end

`ifdef EDA_FLOOD_STATS_EN
    localparam int unsigned CW = ADDR_WIDTH + 1;
    logic [CW-1:0] region_count_q, max_region_count_q;

    // Counts advance in the same cycle region_done rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            region_count_q     <= '0;
            max_region_count_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            region_count_q     <= '0;
            max_region_count_q <= '0;
        end else if (mask_en_q && mask_last_q) begin
            region_count_q <= region_count_q + CW'(1);
            if (mask_data_q) max_region_count_q <= max_region_count_q + CW'(1);
        end
    end

    assign region_count     = region_count_q;
    assign max_region_count = max_region_count_q;
`endif

    assign busy             = busy_q;
    assign done             = done_q;
    assign win_req_valid    = win_req_valid_q;
    assign win_center_addr  = win_center_addr_q;
    assign neigh_addr_valid = nav_q;
    assign iterated_idx     = iter_q;
    assign mask_wr_en       = mask_en_q;
    assign mask_wr_addr     = mask_addr_q;
    assign mask_wr_data     = mask_data_q;
    assign region_done      = region_done_q;

endmodule
